// File: rtl/mem_access.sv
// MEM stage: runs loads/stores on a req/ack data bus, stalls the pipeline while
// an access is outstanding, and produces the write-back triple for MEM/WB.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [31:0]   load_data_r;
  logic          tmo_r;

  logic          is_load_s;
  logic          is_store_s;
  logic          misalign_s;
  logic [3:0]    sel_s;
  logic [31:0]   sdata_rep_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic [31:0]   ext_s;

  // Operation decode: lane enables, replicated store data and alignment.
  always_comb begin
    is_load_s   = 1'b0;
    is_store_s  = 1'b0;
    misalign_s  = 1'b0;
    sel_s       = 4'b0000;
    sdata_rep_s = 32'h0000_0000;
    case (mem_op)
      OP_LB, OP_LBU, OP_SB: begin
        sel_s       = 4'b1000 >> mem_addr[1:0];
        sdata_rep_s = {4{mem_sdata[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        sel_s       = mem_addr[1] ? 4'b0011 : 4'b1100;
        sdata_rep_s = {2{mem_sdata[15:0]}};
        misalign_s  = mem_addr[0];
      end
      OP_LW, OP_SW: begin
        sel_s       = 4'b1111;
        sdata_rep_s = mem_sdata;
        misalign_s  = (mem_addr[1:0] != 2'b00);
      end
      default: begin
        sel_s       = 4'b0000;
      end
    endcase
    if ((mem_op >= OP_LB) && (mem_op <= OP_LW)) begin
      is_load_s = 1'b1;
    end else begin
      is_load_s = 1'b0;
    end
    if ((mem_op >= OP_SB) && (mem_op <= OP_SW)) begin
      is_store_s = 1'b1;
    end else begin
      is_store_s = 1'b0;
    end
  end

  // Big-endian lane extraction and sign/zero extension of the read data.
  always_comb begin
    byte_s = 8'h00;
    case (mem_addr[1:0])
      2'd0:    byte_s = bus_rdata[31:24];
      2'd1:    byte_s = bus_rdata[23:16];
      2'd2:    byte_s = bus_rdata[15:8];
      2'd3:    byte_s = bus_rdata[7:0];
      default: byte_s = 8'h00;
    endcase
    half_s = mem_addr[1] ? bus_rdata[15:0] : bus_rdata[31:16];
    case (mem_op)
      OP_LB:   ext_s = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  ext_s = {24'h00_0000, byte_s};
      OP_LH:   ext_s = {{16{half_s[15]}}, half_s};
      OP_LHU:  ext_s = {16'h0000, half_s};
      OP_LW:   ext_s = bus_rdata;
      default: ext_s = 32'h0000_0000;
    endcase
  end

  // Access FSM, timeout counter and registered bus request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      load_data_r <= 32'h0000_0000;
      tmo_r       <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'h0000_0000;
      bus_sel     <= 4'b0000;
      bus_wdata   <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          tmo_r <= 1'b0;
          if ((is_load_s || is_store_s) && !misalign_s) begin
            state_r   <= BUSY;
            cnt_r     <= '0;
            bus_req   <= 1'b1;
            bus_we    <= is_store_s;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_sel   <= sel_s;
            bus_wdata <= is_store_s ? sdata_rep_s : 32'h0000_0000;
          end
        end
        BUSY: begin
          if (bus_ack || (cnt_r == CNT_LAST)) begin
            // Leaving BUSY either way releases the bus; only a real ack carries data.
            state_r   <= DONE;
            tmo_r     <= !bus_ack;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0000_0000;
            bus_sel   <= 4'b0000;
            bus_wdata <= 32'h0000_0000;
            if (bus_ack) begin
              load_data_r <= ext_s;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          tmo_r   <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          tmo_r   <= 1'b0;
        end
      endcase
    end
  end

  // Write-back, stall and error outputs for the current cycle.
  always_comb begin
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = 32'h0000_0000;
    stallreq_o = 1'b0;
    err_o      = 1'b0;
    if (!rst) begin
      wd_o = 5'd0;
    end else begin
      wd_o    = mem_wd;
      wdata_o = mem_wdata;
      case (state_r)
        IDLE: begin
          if (!(is_load_s || is_store_s)) begin
            wreg_o = mem_wreg;
          end else if (misalign_s) begin
            err_o = 1'b1;
          end else begin
            stallreq_o = 1'b1;
          end
        end
        BUSY: begin
          stallreq_o = 1'b1;
        end
        DONE: begin
          if (tmo_r) begin
            err_o = 1'b1;
          end else if (is_load_s) begin
            wreg_o  = mem_wreg;
            wdata_o = load_data_r;
          end else begin
            wreg_o = 1'b0;
          end
        end
        default: begin
          stallreq_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized ops
// checked against a byte-lane reference model.
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic        err_o;

  int checks = 0;
  int passes = 0;

  mem_access #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_wdata(mem_wdata), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_sdata(mem_sdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .stallreq_o(stallreq_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int op_size(input int op);
    case (op)
      1, 2, 6: return 1;
      3, 4, 7: return 2;
      5, 8:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit op_is_load(input int op);
    return (op >= 1) && (op <= 5);
  endfunction

  function automatic bit op_signed(input int op);
    return (op == 1) || (op == 3);
  endfunction

  function automatic bit op_misaligned(input int op, input logic [31:0] addr);
    int s;
    s = op_size(op);
    return (s > 1) && ((addr % s) != 0);
  endfunction

  // Bytes numbered from the MSB (big-endian): byte j of the word is lane bit 3-j.
  function automatic logic [3:0] model_sel(input int op, input logic [31:0] addr);
    logic [3:0] s;
    int k;
    int sz;
    sz = op_size(op);
    k = addr % 4;
    s = 4'b0000;
    for (int j = k; j < k + sz; j++) s[3 - j] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input int op, input logic [31:0] sd);
    logic [31:0] w;
    int sz;
    sz = op_size(op);
    w = 32'h0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input int op, input logic [31:0] addr, input logic [31:0] rd);
    longint v;
    int sz;
    int k;
    sz = op_size(op);
    k = addr % 4;
    v = (longint'(rd) >> (8 * (4 - k - sz))) & ((longint'(1) << (8 * sz)) - 1);
    if (op_signed(op) && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  // ---------------- scenario helpers ----------------
  task automatic apply(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    mem_op = op; mem_addr = addr; mem_sdata = sd;
    mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
  endtask

  // Runs one aligned memory op, acking in BUSY cycle ack_at (0 = first).
  task automatic run_mem_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                            input logic [31:0] rd, input int ack_at,
                            input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    logic [3:0]  e_sel;
    logic [31:0] e_wd;
    logic [31:0] e_ld;
    logic        st;
    e_sel = model_sel(op, addr);
    e_wd  = model_wdata(op, sd);
    e_ld  = model_load(op, addr, rd);
    st    = !op_is_load(op);
    @(negedge clk);
    apply(op, addr, sd, wd, wreg, wdata);
    #1;
    checks++; if (stallreq_o !== 1'b1) $display("FAIL idle_stall op=%0d got=%b exp=1", op, stallreq_o); else passes++;
    checks++; if (wreg_o !== 1'b0) $display("FAIL idle_wreg op=%0d got=%b exp=0", op, wreg_o); else passes++;
    for (int c = 0; c <= ack_at; c++) begin
      @(negedge clk);
      #1;
      checks++; if (bus_req !== 1'b1 || stallreq_o !== 1'b1 || wreg_o !== 1'b0)
        $display("FAIL busy_req op=%0d cyc=%0d got req=%b stall=%b wreg=%b exp 1 1 0", op, c, bus_req, stallreq_o, wreg_o); else passes++;
      checks++; if (bus_addr !== {addr[31:2], 2'b00}) $display("FAIL bus_addr got=%h exp=%h", bus_addr, {addr[31:2], 2'b00}); else passes++;
      checks++; if (bus_sel !== e_sel) $display("FAIL bus_sel op=%0d addr=%h got=%b exp=%b", op, addr, bus_sel, e_sel); else passes++;
      checks++; if (bus_we !== st) $display("FAIL bus_we op=%0d got=%b exp=%b", op, bus_we, st); else passes++;
      if (st) begin
        checks++; if (bus_wdata !== e_wd) $display("FAIL bus_wdata op=%0d got=%h exp=%h", op, bus_wdata, e_wd); else passes++;
      end
      if (c == ack_at) begin
        bus_ack = 1'b1;
        bus_rdata = rd;
      end
    end
    @(negedge clk);
    bus_ack = 1'b0;
    bus_rdata = $urandom;
    #1;
    checks++; if (stallreq_o !== 1'b0 || err_o !== 1'b0 || bus_req !== 1'b0)
      $display("FAIL done_ctrl op=%0d got stall=%b err=%b req=%b exp 0 0 0", op, stallreq_o, err_o, bus_req); else passes++;
    checks++; if (wd_o !== wd) $display("FAIL done_wd got=%0d exp=%0d", wd_o, wd); else passes++;
    checks++; if (wreg_o !== (st ? 1'b0 : wreg)) $display("FAIL done_wreg op=%0d got=%b exp=%b", op, wreg_o, st ? 1'b0 : wreg); else passes++;
    checks++; if (wdata_o !== (st ? wdata : e_ld)) $display("FAIL done_wdata op=%0d got=%h exp=%h", op, wdata_o, st ? wdata : e_ld); else passes++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    apply(4'd0, 32'h0000_0104, 32'h5555_AAAA, 5'd17, 1'b1, 32'hCAFE_F00D);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 || bus_sel !== 4'h0 || bus_wdata !== 32'h0)
      $display("FAIL reset_bus got req=%b we=%b addr=%h sel=%b wd=%h exp all 0", bus_req, bus_we, bus_addr, bus_sel, bus_wdata); else passes++;
    checks++; if (wd_o !== 5'd0 || wreg_o !== 1'b0 || wdata_o !== 32'h0 || stallreq_o !== 1'b0 || err_o !== 1'b0)
      $display("FAIL reset_comb got wd=%0d wreg=%b wdata=%h stall=%b err=%b exp all 0", wd_o, wreg_o, wdata_o, stallreq_o, err_o); else passes++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_nop();
    @(negedge clk);
    apply(4'd0, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0000_1234);
    #1;
    checks++; if (wd_o !== 5'd3 || wreg_o !== 1'b1 || wdata_o !== 32'h1234 || stallreq_o !== 1'b0)
      $display("FAIL nop_pass got wd=%0d wreg=%b wdata=%h stall=%b exp 3 1 1234 0", wd_o, wreg_o, wdata_o, stallreq_o); else passes++;
    @(negedge clk);
    apply(4'd12, 32'h0000_0200, 32'h0, 5'd30, 1'b0, 32'h8765_4321);
    #1;
    checks++; if (wd_o !== 5'd30 || wreg_o !== 1'b0 || wdata_o !== 32'h8765_4321 || stallreq_o !== 1'b0 || bus_req !== 1'b0)
      $display("FAIL nop_op12 got wd=%0d wreg=%b wdata=%h stall=%b req=%b", wd_o, wreg_o, wdata_o, stallreq_o, bus_req); else passes++;
  endtask

  task automatic test_loads_stores();
    run_mem_op(4'd1, 32'h0000_0103, 32'h0, 32'h1122_33F0, 0, 5'd9, 1'b1, 32'hDEAD_0000);
    run_mem_op(4'd2, 32'h0000_0103, 32'h0, 32'h1122_33F0, 0, 5'd9, 1'b1, 32'hDEAD_0000);
    checks++; if (wdata_o !== 32'h0000_00F0) $display("FAIL lbu_const got=%h exp=000000f0", wdata_o); else passes++;
    run_mem_op(4'd7, 32'h0000_0202, 32'h1357_BEEF, 32'h0, 1, 5'd4, 1'b1, 32'h0000_0202);
    run_mem_op(4'd3, 32'h0000_0300, 32'h0, 32'h8001_7FFF, 2, 5'd5, 1'b1, 32'h0);
  endtask

  task automatic test_back_to_back();
    run_mem_op(4'd5, 32'h0000_1000, 32'h0, 32'hA5A5_5A5A, 0, 5'd1, 1'b1, 32'h0);
    run_mem_op(4'd8, 32'h0000_1004, 32'h0BAD_CAFE, 32'h0, 0, 5'd2, 1'b1, 32'h1111_1111);
    run_mem_op(4'd4, 32'h0000_1006, 32'h0, 32'h1234_F00D, 0, 5'd3, 1'b1, 32'h0);
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    apply(4'd5, 32'h0000_0301, 32'h0, 5'd6, 1'b1, 32'h0);
    #1;
    checks++; if (err_o !== 1'b1 || wreg_o !== 1'b0 || stallreq_o !== 1'b0)
      $display("FAIL misalign_lw got err=%b wreg=%b stall=%b exp 1 0 0", err_o, wreg_o, stallreq_o); else passes++;
    @(negedge clk);
    #1;
    checks++; if (bus_req !== 1'b0) $display("FAIL misalign_noreq got=%b exp=0", bus_req); else passes++;
    apply(4'd7, 32'h0000_0203, 32'h0, 5'd6, 1'b1, 32'h0);
    #1;
    checks++; if (err_o !== 1'b1 || stallreq_o !== 1'b0) $display("FAIL misalign_sh got err=%b stall=%b exp 1 0", err_o, stallreq_o); else passes++;
  endtask

  task automatic test_timeout();
    int hi;
    hi = 0;
    @(negedge clk);
    apply(4'd5, 32'h0000_0400, 32'h0, 5'd8, 1'b1, 32'h0000_0777);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (bus_req === 1'b1) hi++;
      else break;
    end
    checks++; if (hi != 16) $display("FAIL timeout_len got=%0d exp=16", hi); else passes++;
    checks++; if (err_o !== 1'b1 || wreg_o !== 1'b0 || stallreq_o !== 1'b0)
      $display("FAIL timeout_done got err=%b wreg=%b stall=%b exp 1 0 0", err_o, wreg_o, stallreq_o); else passes++;
    @(negedge clk);
    apply(4'd0, 32'h0, 32'h0, 5'd8, 1'b0, 32'h0);
    #1;
    checks++; if (err_o !== 1'b0 || bus_req !== 1'b0 || stallreq_o !== 1'b0)
      $display("FAIL timeout_idle got err=%b req=%b stall=%b exp 0 0 0", err_o, bus_req, stallreq_o); else passes++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    apply(4'd5, 32'h0000_0500, 32'h0, 5'd7, 1'b1, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus_req !== 1'b1) $display("FAIL rstmid_busy got=%b exp=1", bus_req); else passes++;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    apply(4'd0, 32'h0, 32'h0, 5'd7, 1'b0, 32'h0000_A5A5);
    #1;
    checks++; if (bus_req !== 1'b0 || stallreq_o !== 1'b0) $display("FAIL rstmid_clear got req=%b stall=%b exp 0 0", bus_req, stallreq_o); else passes++;
    @(negedge clk);
    @(negedge clk);
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (wreg_o !== 1'b0 || wdata_o !== 32'h0000_A5A5 || stallreq_o !== 1'b0)
      $display("FAIL rstmid_ack got wreg=%b wdata=%h stall=%b exp 0 a5a5 0", wreg_o, wdata_o, stallreq_o); else passes++;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    checks++; if (wreg_o !== 1'b0 || err_o !== 1'b0 || bus_req !== 1'b0)
      $display("FAIL rstmid_after got wreg=%b err=%b req=%b exp 0 0 0", wreg_o, err_o, bus_req); else passes++;
    run_mem_op(4'd5, 32'h0000_0504, 32'h0, 32'h0102_0304, 1, 5'd7, 1'b1, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] sd;
      logic [4:0]  wd;
      logic        wr;
      logic [31:0] wdat;
      op = 4'($urandom_range(0, 15));
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
      if ($urandom_range(0, 1) != 0) addr[0] = 1'b0;
      sd = $urandom; wd = 5'($urandom); wr = 1'($urandom); wdat = $urandom;
      if (op_size(op) == 0) begin
        @(negedge clk);
        apply(op, addr, sd, wd, wr, wdat);
        #1;
        checks++; if (wd_o !== wd || wreg_o !== wr || wdata_o !== wdat || stallreq_o !== 1'b0 || err_o !== 1'b0 || bus_req !== 1'b0)
          $display("FAIL rnd_nop op=%0d got wd=%0d wreg=%b wdata=%h stall=%b err=%b", op, wd_o, wreg_o, wdata_o, stallreq_o, err_o); else passes++;
      end else if (op_misaligned(op, addr)) begin
        @(negedge clk);
        apply(op, addr, sd, wd, wr, wdat);
        #1;
        checks++; if (err_o !== 1'b1 || wreg_o !== 1'b0 || stallreq_o !== 1'b0 || bus_req !== 1'b0)
          $display("FAIL rnd_misalign op=%0d addr=%h got err=%b wreg=%b stall=%b", op, addr, err_o, wreg_o, stallreq_o); else passes++;
      end else begin
        run_mem_op(op, addr, sd, $urandom, $urandom_range(0, 3), wd, wr, wdat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_loads_stores();
    test_back_to_back();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_random();
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
